// File: rtl/arp_tbl_arbiter_if.sv
// Request/ack, table-port and statistics signals of the ARP table arbiter.
// slave is the arbiter's view; master is the requesters' and table's view.
interface arp_tbl_arbiter_if #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32
);
  localparam int unsigned W = 3 * C_S_AXI_DATA_WIDTH;

  logic                          lkup_req;
  logic [4:0]                    lkup_addr;
  logic                          lkup_ack;
  logic [W-1:0]                  lkup_data;
  logic                          host_rd_req;
  logic [4:0]                    host_rd_addr;
  logic                          host_rd_ack;
  logic [W-1:0]                  host_rd_data;
  logic                          host_wr_req;
  logic [4:0]                    host_wr_addr;
  logic [W-1:0]                  host_wr_data;
  logic                          host_wr_ack;
  logic                          tbl_rd_req;
  logic                          tbl_wr_req;
  logic [4:0]                    tbl_rd_addr;
  logic [4:0]                    tbl_wr_addr;
  logic [W-1:0]                  tbl_wr_data;
  logic [W-1:0]                  tbl_rd_data;
  logic                          tbl_rd_ack;
  logic                          tbl_wr_ack;
  logic [C_S_AXI_DATA_WIDTH-1:0] drop_count;
  logic [C_S_AXI_DATA_WIDTH-1:0] timeout_count;

  modport slave (
    input  lkup_req, lkup_addr, host_rd_req, host_rd_addr, host_wr_req, host_wr_addr,
           host_wr_data, tbl_rd_data, tbl_rd_ack, tbl_wr_ack,
    output lkup_ack, lkup_data, host_rd_ack, host_rd_data, host_wr_ack, tbl_rd_req,
           tbl_wr_req, tbl_rd_addr, tbl_wr_addr, tbl_wr_data, drop_count, timeout_count
  );

  modport master (
    output lkup_req, lkup_addr, host_rd_req, host_rd_addr, host_wr_req, host_wr_addr,
           host_wr_data, tbl_rd_data, tbl_rd_ack, tbl_wr_ack,
    input  lkup_ack, lkup_data, host_rd_ack, host_rd_data, host_wr_ack, tbl_rd_req,
           tbl_wr_req, tbl_rd_addr, tbl_wr_addr, tbl_wr_data, drop_count, timeout_count
  );
endinterface

// File: rtl/arp_tbl_arbiter.sv
// Serialises datapath lookups and host reads/writes onto the single ARP table port,
// holding one pending request per source and returning registered acks and data.
module arp_tbl_arbiter #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_MAX_LKUP_BURST   = 4,
  parameter int unsigned C_ACK_TIMEOUT      = 8
) (
  input logic              AXI_ACLK,
  input logic              AXI_RESET,
  arp_tbl_arbiter_if.slave bus
);
  localparam int unsigned DW      = C_S_AXI_DATA_WIDTH;
  localparam int unsigned W       = 3 * DW;
  localparam int unsigned StreakW = $clog2(C_MAX_LKUP_BURST + 1);
  localparam int unsigned WaitW   = $clog2(C_ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
  typedef enum logic [1:0] {SrcLkup, SrcHostRd, SrcHostWr} src_e;

  state_e state_q, state_d;
  src_e   sel_q, sel_d, win;

  logic               lkup_pend_q, lkup_pend_d, rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic [4:0]         lkup_addr_q, lkup_addr_d, rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [W-1:0]       wr_data_q, wr_data_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic               lkup_ack_q, lkup_ack_d, host_rd_ack_q, host_rd_ack_d;
  logic               host_wr_ack_q, host_wr_ack_d;
  logic [W-1:0]       lkup_data_q, lkup_data_d, host_rd_data_q, host_rd_data_d;
  logic               tbl_rd_req_q, tbl_rd_req_d, tbl_wr_req_q, tbl_wr_req_d;
  logic [4:0]         tbl_rd_addr_q, tbl_rd_addr_d, tbl_wr_addr_q, tbl_wr_addr_d;
  logic [W-1:0]       tbl_wr_data_q, tbl_wr_data_d;
  logic [DW-1:0]      drop_count_q, drop_count_d, timeout_count_q, timeout_count_d;

  logic          any_pend, grant, ack_hit, expired, done;
  logic [1:0]    n_drop;
  logic [DW:0]   drop_sum;
  logic [W-1:0]  rd_data;

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      state_q <= StIdle;
      sel_q   <= SrcLkup;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    any_pend = lkup_pend_q | rd_pend_q | wr_pend_q;
    // A host read starved by a full lookup burst beats every other source.
    if (rd_pend_q && streak_q == StreakW'(C_MAX_LKUP_BURST)) win = SrcHostRd;
    else if (wr_pend_q)                                      win = SrcHostWr;
    else if (lkup_pend_q)                                    win = SrcLkup;
    else                                                     win = SrcHostRd;
    grant   = (state_q == StIdle) && any_pend;
    ack_hit = (state_q == StWait) &&
              ((sel_q == SrcHostWr) ? bus.tbl_wr_ack : bus.tbl_rd_ack);
    expired = (state_q == StWait) && !ack_hit && (wait_cnt_q == WaitW'(C_ACK_TIMEOUT - 1));
    done    = ack_hit | expired;

    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (any_pend) begin
          state_d = StIssue;
          sel_d   = win;
        end
      end
      StIssue: state_d = StWait;
      StWait:  if (done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_data        = ack_hit ? bus.tbl_rd_data : '0;
    lkup_ack_d     = done && (sel_q == SrcLkup);
    host_rd_ack_d  = done && (sel_q == SrcHostRd);
    host_wr_ack_d  = done && (sel_q == SrcHostWr);
    lkup_data_d    = lkup_ack_d ? rd_data : '0;
    host_rd_data_d = host_rd_ack_d ? rd_data : '0;

    tbl_rd_req_d  = grant && (win != SrcHostWr);
    tbl_wr_req_d  = grant && (win == SrcHostWr);
    tbl_rd_addr_d = tbl_rd_req_d ? ((win == SrcLkup) ? lkup_addr_q : rd_addr_q) : tbl_rd_addr_q;
    tbl_wr_addr_d = tbl_wr_req_d ? wr_addr_q : tbl_wr_addr_q;
    tbl_wr_data_d = tbl_wr_req_d ? wr_data_q : tbl_wr_data_q;

    // A pending flag is released on the edge that raises its ack.
    lkup_pend_d = lkup_pend_q ? !lkup_ack_d : bus.lkup_req;
    rd_pend_d   = rd_pend_q ? !host_rd_ack_d : bus.host_rd_req;
    wr_pend_d   = wr_pend_q ? !host_wr_ack_d : bus.host_wr_req;
    lkup_addr_d = (!lkup_pend_q && bus.lkup_req) ? bus.lkup_addr : lkup_addr_q;
    rd_addr_d   = (!rd_pend_q && bus.host_rd_req) ? bus.host_rd_addr : rd_addr_q;
    wr_addr_d   = (!wr_pend_q && bus.host_wr_req) ? bus.host_wr_addr : wr_addr_q;
    wr_data_d   = (!wr_pend_q && bus.host_wr_req) ? bus.host_wr_data : wr_data_q;

    n_drop = 2'(lkup_pend_q & bus.lkup_req) + 2'(rd_pend_q & bus.host_rd_req) +
             2'(wr_pend_q & bus.host_wr_req);
    drop_sum     = {1'b0, drop_count_q} + (DW + 1)'(n_drop);
    drop_count_d = drop_sum[DW] ? '1 : drop_sum[DW-1:0];
    timeout_count_d = (expired && timeout_count_q != '1) ? timeout_count_q + DW'(1)
                                                          : timeout_count_q;

    if (!rd_pend_q)                    streak_d = '0;
    else if (grant && win == SrcHostRd) streak_d = '0;
    else if (grant && win == SrcLkup)   streak_d = streak_q + StreakW'(1);
    else                                streak_d = streak_q;
    wait_cnt_d = (state_q == StWait) ? wait_cnt_q + WaitW'(1) : '0;
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      lkup_pend_q     <= 1'b0;
      rd_pend_q       <= 1'b0;
      wr_pend_q       <= 1'b0;
      lkup_addr_q     <= '0;
      rd_addr_q       <= '0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      streak_q        <= '0;
      wait_cnt_q      <= '0;
      lkup_ack_q      <= 1'b0;
      host_rd_ack_q   <= 1'b0;
      host_wr_ack_q   <= 1'b0;
      lkup_data_q     <= '0;
      host_rd_data_q  <= '0;
      tbl_rd_req_q    <= 1'b0;
      tbl_wr_req_q    <= 1'b0;
      tbl_rd_addr_q   <= '0;
      tbl_wr_addr_q   <= '0;
      tbl_wr_data_q   <= '0;
      drop_count_q    <= '0;
      timeout_count_q <= '0;
    end else begin
      lkup_pend_q     <= lkup_pend_d;
      rd_pend_q       <= rd_pend_d;
      wr_pend_q       <= wr_pend_d;
      lkup_addr_q     <= lkup_addr_d;
      rd_addr_q       <= rd_addr_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      streak_q        <= streak_d;
      wait_cnt_q      <= wait_cnt_d;
      lkup_ack_q      <= lkup_ack_d;
      host_rd_ack_q   <= host_rd_ack_d;
      host_wr_ack_q   <= host_wr_ack_d;
      lkup_data_q     <= lkup_data_d;
      host_rd_data_q  <= host_rd_data_d;
      tbl_rd_req_q    <= tbl_rd_req_d;
      tbl_wr_req_q    <= tbl_wr_req_d;
      tbl_rd_addr_q   <= tbl_rd_addr_d;
      tbl_wr_addr_q   <= tbl_wr_addr_d;
      tbl_wr_data_q   <= tbl_wr_data_d;
      drop_count_q    <= drop_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign bus.lkup_ack      = lkup_ack_q;
  assign bus.lkup_data     = lkup_data_q;
  assign bus.host_rd_ack   = host_rd_ack_q;
  assign bus.host_rd_data  = host_rd_data_q;
  assign bus.host_wr_ack   = host_wr_ack_q;
  assign bus.tbl_rd_req    = tbl_rd_req_q;
  assign bus.tbl_wr_req    = tbl_wr_req_q;
  assign bus.tbl_rd_addr   = tbl_rd_addr_q;
  assign bus.tbl_wr_addr   = tbl_wr_addr_q;
  assign bus.tbl_wr_data   = tbl_wr_data_q;
  assign bus.drop_count    = drop_count_q;
  assign bus.timeout_count = timeout_count_q;
endmodule

// File: tb/tb_arp_tbl_arbiter.sv
// Directed bench for arp_tbl_arbiter: a behavioural table with a strobe scoreboard,
// plus cycle-exact checks of acks, data, counters and reset behaviour.
module tb_arp_tbl_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned W  = 3 * DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arp_tbl_arbiter_if #(.C_S_AXI_DATA_WIDTH(DW)) bus ();

  arp_tbl_arbiter #(
    .C_S_AXI_DATA_WIDTH(DW),
    .C_MAX_LKUP_BURST  (4),
    .C_ACK_TIMEOUT     (8)
  ) dut (
    .AXI_ACLK (clk),
    .AXI_RESET(rst),
    .bus      (bus)
  );

  typedef struct {
    bit           wr;
    logic [4:0]   addr;
    logic [W-1:0] data;
  } strobe_t;

  strobe_t      exp_q[$];
  logic [W-1:0] mem[32];
  bit           withhold = 1'b0;
  int           total = 0;
  int           passed = 0;

  function automatic logic [W-1:0] pattern(input int a);
    return {32'hC0DE_0000 | 32'(a), 32'h1234_5600 | 32'(a), ~32'(a)};
  endfunction

  function automatic logic [W-1:0] wdata(input int i);
    return {32'hDA7A_0000 | 32'(i), 32'h5A5A_5A5A, 32'(i) * 32'h0101_0101};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    check(tag, W'(got), W'(exp));
  endtask

  task automatic push_exp(input bit wr, input logic [4:0] a, input logic [W-1:0] d);
    strobe_t e;
    e.wr = wr;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Table model: acks one cycle after each strobe; every strobe is scored in order.
  initial begin
    logic       prev_rd, prev_wr;
    logic [4:0] prev_addr;
    strobe_t    e;
    prev_rd = 1'b0;
    prev_wr = 1'b0;
    prev_addr = '0;
    bus.tbl_rd_ack = 1'b0;
    bus.tbl_wr_ack = 1'b0;
    bus.tbl_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.tbl_rd_ack  = prev_rd && !withhold;
      bus.tbl_wr_ack  = prev_wr && !withhold;
      bus.tbl_rd_data = (prev_rd && !withhold) ? mem[prev_addr] : '0;
      prev_rd   = bus.tbl_rd_req;
      prev_wr   = bus.tbl_wr_req;
      prev_addr = bus.tbl_rd_addr;
      if (bus.tbl_wr_req) mem[bus.tbl_wr_addr] = bus.tbl_wr_data;
      if (bus.tbl_rd_req || bus.tbl_wr_req) begin
        if (exp_q.size() == 0) begin
          chk_bit("strobe_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk_bit("strobe_kind", bus.tbl_wr_req, e.wr);
          check("strobe_addr", W'(e.wr ? bus.tbl_wr_addr : bus.tbl_rd_addr), W'(e.addr));
          if (e.wr) check("strobe_data", bus.tbl_wr_data, e.data);
        end
      end
    end
  end

  initial begin
    logic seen;
    rst = 1'b1;
    bus.lkup_req = 1'b0;     bus.lkup_addr = '0;
    bus.host_rd_req = 1'b0;  bus.host_rd_addr = '0;
    bus.host_wr_req = 1'b0;  bus.host_wr_addr = '0;  bus.host_wr_data = '0;
    for (int i = 0; i < 32; i++) mem[i] = pattern(i);

    step(2);
    chk_bit("rst_lkup_ack", bus.lkup_ack, 1'b0);
    chk_bit("rst_host_rd_ack", bus.host_rd_ack, 1'b0);
    chk_bit("rst_host_wr_ack", bus.host_wr_ack, 1'b0);
    chk_bit("rst_tbl_rd_req", bus.tbl_rd_req, 1'b0);
    chk_bit("rst_tbl_wr_req", bus.tbl_wr_req, 1'b0);
    check("rst_lkup_data", bus.lkup_data, '0);
    check("rst_drop_count", W'(bus.drop_count), '0);
    check("rst_timeout_count", W'(bus.timeout_count), '0);
    rst = 1'b0;
    step(1);

    // Host write then read-back of the same entry.
    bus.host_wr_req = 1'b1; bus.host_wr_addr = 5'd5; bus.host_wr_data = wdata(100);
    push_exp(1'b1, 5'd5, wdata(100));
    step(1); bus.host_wr_req = 1'b0;
    step(2); chk_bit("wr_ack_early", bus.host_wr_ack, 1'b0);
    step(1); chk_bit("wr_ack_n4", bus.host_wr_ack, 1'b1);
    bus.host_rd_req = 1'b1; bus.host_rd_addr = 5'd5;
    push_exp(1'b0, 5'd5, '0);
    step(1); bus.host_rd_req = 1'b0;
    step(2); chk_bit("rd_ack_early", bus.host_rd_ack, 1'b0);
    step(1); chk_bit("rd_ack_n4", bus.host_rd_ack, 1'b1);
    check("rd_data_raw", bus.host_rd_data, wdata(100));
    step(1); chk_bit("rd_ack_one_cycle", bus.host_rd_ack, 1'b0);
    check("rd_data_cleared", bus.host_rd_data, '0);
    check("no_drops", W'(bus.drop_count), '0);

    // Simultaneous lookup and host write: write first, lookup sees the new value.
    bus.lkup_req = 1'b1; bus.lkup_addr = 5'd9;
    bus.host_wr_req = 1'b1; bus.host_wr_addr = 5'd9; bus.host_wr_data = wdata(101);
    push_exp(1'b1, 5'd9, wdata(101));
    push_exp(1'b0, 5'd9, '0);
    step(1); bus.lkup_req = 1'b0; bus.host_wr_req = 1'b0;
    step(3); chk_bit("prio_wr_ack_n4", bus.host_wr_ack, 1'b1);
    step(2); chk_bit("prio_lkup_ack_early", bus.lkup_ack, 1'b0);
    step(1); chk_bit("prio_lkup_ack_n7", bus.lkup_ack, 1'b1);
    check("prio_lkup_data", bus.lkup_data, wdata(101));
    step(1);

    // Duplicate lookup is dropped; a pulse in the ack cycle is accepted.
    bus.lkup_req = 1'b1; bus.lkup_addr = 5'd3;
    push_exp(1'b0, 5'd3, '0);
    step(1); bus.lkup_addr = 5'd4;
    step(1); bus.lkup_req = 1'b0;
    step(2); chk_bit("drop_lkup_ack", bus.lkup_ack, 1'b1);
    check("drop_lkup_data", bus.lkup_data, pattern(3));
    bus.lkup_req = 1'b1; bus.lkup_addr = 5'd4;
    push_exp(1'b0, 5'd4, '0);
    step(1); bus.lkup_req = 1'b0;
    step(3); chk_bit("ackcycle_lkup_ack", bus.lkup_ack, 1'b1);
    check("ackcycle_lkup_data", bus.lkup_data, pattern(4));
    check("drop_count_1", W'(bus.drop_count), W'(1));
    step(1);

    // Starvation: writes and lookups ping-pong while a host read waits.
    bus.host_wr_req = 1'b1; bus.host_wr_addr = 5'd16; bus.host_wr_data = wdata(0);
    bus.lkup_req = 1'b1; bus.lkup_addr = 5'd1;
    bus.host_rd_req = 1'b1; bus.host_rd_addr = 5'd2;
    push_exp(1'b1, 5'd16, wdata(0));
    push_exp(1'b0, 5'd1, '0);
    step(1); bus.host_wr_req = 1'b0; bus.lkup_req = 1'b0; bus.host_rd_req = 1'b0;
    step(3);
    for (int i = 0; i < 4; i++) begin
      chk_bit("burst_wr_ack", bus.host_wr_ack, 1'b1);
      bus.host_wr_req = 1'b1; bus.host_wr_addr = 5'(17 + i); bus.host_wr_data = wdata(i + 1);
      if (i == 3) push_exp(1'b0, 5'd2, '0);
      push_exp(1'b1, 5'(17 + i), wdata(i + 1));
      step(1); bus.host_wr_req = 1'b0;
      step(2);
      chk_bit("burst_lkup_ack", bus.lkup_ack, 1'b1);
      check("burst_lkup_data", bus.lkup_data, pattern(1 + i));
      if (i < 3) begin
        bus.lkup_req = 1'b1; bus.lkup_addr = 5'(2 + i);
        push_exp(1'b0, 5'(2 + i), '0);
      end
      step(1); bus.lkup_req = 1'b0;
      step(2);
    end
    chk_bit("starve_rd_ack", bus.host_rd_ack, 1'b1);
    chk_bit("starve_wr_waits", bus.host_wr_ack, 1'b0);
    check("starve_rd_data", bus.host_rd_data, pattern(2));
    step(3); chk_bit("starve_wr_after", bus.host_wr_ack, 1'b1);
    check("drop_count_still_1", W'(bus.drop_count), W'(1));
    step(1);

    // Withheld table ack: lookup aborts with zero data, then host read proceeds.
    withhold = 1'b1;
    bus.lkup_req = 1'b1; bus.lkup_addr = 5'd12;
    bus.host_rd_req = 1'b1; bus.host_rd_addr = 5'd13;
    push_exp(1'b0, 5'd12, '0);
    push_exp(1'b0, 5'd13, '0);
    step(1); bus.lkup_req = 1'b0; bus.host_rd_req = 1'b0;
    step(9); chk_bit("to_lkup_ack_early", bus.lkup_ack, 1'b0);
    step(1); chk_bit("to_lkup_ack", bus.lkup_ack, 1'b1);
    check("to_lkup_data", bus.lkup_data, '0);
    check("to_count", W'(bus.timeout_count), W'(1));
    withhold = 1'b0;
    step(3); chk_bit("to_next_rd_ack", bus.host_rd_ack, 1'b1);
    check("to_next_rd_data", bus.host_rd_data, pattern(13));
    step(1);

    // Reset while the write strobe is out: everything clears and no ack follows.
    bus.lkup_req = 1'b1; bus.lkup_addr = 5'd14;
    bus.host_wr_req = 1'b1; bus.host_wr_addr = 5'd15; bus.host_wr_data = wdata(7);
    push_exp(1'b1, 5'd15, wdata(7));
    step(1); bus.lkup_req = 1'b0; bus.host_wr_req = 1'b0;
    step(1); chk_bit("mid_issue_strobe", bus.tbl_wr_req, 1'b1);
    #2; rst = 1'b1;
    #1;
    chk_bit("mid_rst_strobe", bus.tbl_wr_req, 1'b0);
    check("mid_rst_drop", W'(bus.drop_count), '0);
    check("mid_rst_timeout", W'(bus.timeout_count), '0);
    step(1); rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      seen = seen | bus.lkup_ack | bus.host_rd_ack | bus.host_wr_ack |
             bus.tbl_rd_req | bus.tbl_wr_req;
    end
    chk_bit("post_rst_quiet", seen, 1'b0);
    check("scoreboard_empty", W'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/arp_tbl_arbiter.md
# arp_tbl_arbiter

Shares the single read/write access port of the 32-entry ARP table between two requesters: the datapath next-hop lookup (read only) and the host register interface (read and write). Each requester issues single-cycle request pulses. The block holds one pending request per source, serialises all table accesses with a three-state FSM, and returns registered acks and read data. It sits between the output-port-lookup pipeline, the AXI-lite register block and the ARP table storage.

## Interface
- C_S_AXI_DATA_WIDTH, 32, word width; a table entry is 3*C_S_AXI_DATA_WIDTH bits (W below).
- C_MAX_LKUP_BURST, 4, consecutive lookup grants allowed while a host read waits.
- C_ACK_TIMEOUT, 8, WAIT cycles without table ack before abort.
- AXI_ACLK  in  1  clock, single domain.
- AXI_RESET  in  1  reset, asynchronous, active-high.
- lkup_req  in  1  lookup read pulse.
- lkup_addr  in  5  lookup index, sampled with lkup_req.
- lkup_ack  out  1  one-cycle completion pulse.
- lkup_data  out  W  entry, valid while lkup_ack is high.
- host_rd_req  in  1  host read pulse.
- host_rd_addr  in  5  host read index.
- host_rd_ack  out  1  completion pulse.
- host_rd_data  out  W  entry, valid while host_rd_ack is high.
- host_wr_req  in  1  host write pulse.
- host_wr_addr  in  5  host write index.
- host_wr_data  in  W  host write value.
- host_wr_ack  out  1  completion pulse.
- tbl_rd_req, tbl_wr_req  out  1  one-cycle table strobes.
- tbl_rd_addr, tbl_wr_addr  out  5  table indices.
- tbl_wr_data  out  W  table write value.
- tbl_rd_data  in  W  table read value.
- tbl_rd_ack, tbl_wr_ack  in  1  table acks; nominally one cycle after the strobe.
- drop_count  out  C_S_AXI_DATA_WIDTH  count of request pulses discarded because their source was already pending; saturates.
- timeout_count  out  C_S_AXI_DATA_WIDTH  count of aborted accesses; saturates.

## Operation
- Pending capture:
  - Each source has one holding register: pend flag, address and, for writes, data.
  - A pulse is captured at a clock edge only if that source's pend flag is clear at that edge.
  - Otherwise the pulse is dropped, drop_count increments, and the held request is unchanged.
  - The pend flag clears on the edge that raises the source's ack. A pulse arriving during the ack-high cycle is therefore accepted.
- FSM states IDLE, ISSUE, WAIT.
  - IDLE: if any pend flag is set, select a winner and go to ISSUE.
  - ISSUE: for exactly one cycle, drive tbl_rd_req or tbl_wr_req with the winner's address and data. Go to WAIT.
  - WAIT: on the matching table ack, register the table data to the winner's data output, pulse the winner's ack, clear its pend flag, and go to IDLE.
  - WAIT timeout: after C_ACK_TIMEOUT cycles without ack, pulse the winner's ack with data 0, increment timeout_count, and go to IDLE.
- Priority: host write > lookup read > host read, with a starvation override:
  - streak counts lookup grants made while host_rd pend is set.
  - When streak == C_MAX_LKUP_BURST and host_rd pend is set, host read wins next.
  - streak resets to 0 on a host-read grant, or whenever host_rd pend is clear.
- Only one table access is outstanding at a time, so a write always completes before any later-granted read (read-after-write coherent).
- Saturating counters stick at all-ones.
- Async reset, including mid-access: state goes to IDLE; all pend flags, streak, counters, acks, data outputs and tbl_* outputs go to 0. A reset during ISSUE/WAIT abandons the access with no ack.

## Timing
- Reset value of every output is 0.
- All outputs are registered.
- Idle latency: pulse in cycle n → pend visible n+1 (IDLE) → tbl strobe n+2 → table ack n+3 → requester ack and data n+4.
- Back-to-back throughput: one access per 3 cycles (IDLE, ISSUE, WAIT).
- Ack and data outputs are high for exactly one cycle.
- A table ack arriving outside WAIT, or of the wrong type, is ignored.

## Test plan
- Host write addr 5 data X, then host read addr 5 → tbl_wr_req with addr 5; host_wr_ack at n+4; host_rd_data == X; no drops.
- lkup_req and host_wr_req in the same cycle → write issued first, lookup issued 3 cycles later; lkup_ack at n+7.
- Host read pending while lookups are pulsed continuously → host read granted after exactly 4 lookup grants; streak restarts.
- Second lkup_req pulse while lookup is pending → drop_count = 1; the original address is completed. A pulse during the lkup_ack cycle is accepted.
- Table ack withheld → after 8 WAIT cycles the requester ack fires with data 0, timeout_count = 1, and the FSM services the next request.
- AXI_RESET asserted in ISSUE with requests pending → all outputs 0 immediately, no ack after release, counters 0.
